// File: rtl/csr_timer.sv
// CSR timer block: TID/TCFG/TVAL/TICLR registers, a down-counting interrupt
// timer and a free-running 64-bit stable counter for rdcntvl/rdcntvh.
module csr_timer #(
  parameter logic [31:0] CORE_ID = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        csr_wen,
  input  logic [13:0] csr_waddr,
  input  logic [31:0] wdata,
  input  logic [13:0] csr_raddr,
  output logic [31:0] rdata,
  output logic        rhit,
  output logic        timer_int,
  output logic [31:0] cnt_lo,
  output logic [31:0] cnt_hi
);

  localparam logic [13:0] ADDR_TID   = 14'h40;
  localparam logic [13:0] ADDR_TCFG  = 14'h41;
  localparam logic [13:0] ADDR_TVAL  = 14'h42;
  localparam logic [13:0] ADDR_TICLR = 14'h44;

  logic [31:0] tid_q, tid_d;
  logic [31:0] tcfg_q, tcfg_d;
  logic [31:0] tval_q, tval_d;
  logic        timerEn_q, timerEn_d;
  logic        timerInt_q, timerInt_d;
  logic [63:0] stableCnt_q, stableCnt_d;

  logic wrTid, wrTcfg, wrTiclr, expire;

  assign wrTid   = csr_wen && (csr_waddr == ADDR_TID);
  assign wrTcfg  = csr_wen && (csr_waddr == ADDR_TCFG);
  assign wrTiclr = csr_wen && (csr_waddr == ADDR_TICLR);
  assign expire  = timerEn_q && (tval_q == 32'h0);

  // A TCFG write overrides both countdown and expiry; an expiry's set beats a same-cycle clear.
  always_comb begin
    tid_d       = tid_q;
    tcfg_d      = tcfg_q;
    tval_d      = tval_q;
    timerEn_d   = timerEn_q;
    timerInt_d  = timerInt_q;
    stableCnt_d = stableCnt_q + 64'd1;

    if (wrTid) begin
      tid_d = wdata;
    end

    if (wrTcfg) begin
      tcfg_d    = wdata;
      tval_d    = {wdata[31:2], 2'b00};
      timerEn_d = wdata[0];
    end else if (expire) begin
      if (tcfg_q[1]) begin
        tval_d = {tcfg_q[31:2], 2'b00};
      end else begin
        tval_d    = 32'hFFFF_FFFF;
        timerEn_d = 1'b0;
      end
    end else if (timerEn_q) begin
      tval_d = tval_q - 32'd1;
    end

    if (wrTiclr && wdata[0]) begin
      timerInt_d = 1'b0;
    end
    if (expire && !wrTcfg) begin
      timerInt_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tid_q       <= CORE_ID;
      tcfg_q      <= 32'h0;
      tval_q      <= 32'h0;
      timerEn_q   <= 1'b0;
      timerInt_q  <= 1'b0;
      stableCnt_q <= 64'h0;
    end else begin
      tid_q       <= tid_d;
      tcfg_q      <= tcfg_d;
      tval_q      <= tval_d;
      timerEn_q   <= timerEn_d;
      timerInt_q  <= timerInt_d;
      stableCnt_q <= stableCnt_d;
    end
  end

  always_comb begin
    rhit  = 1'b0;
    rdata = 32'h0;
    case (csr_raddr)
      ADDR_TID: begin
        rhit  = 1'b1;
        rdata = tid_q;
      end
      ADDR_TCFG: begin
        rhit  = 1'b1;
        rdata = tcfg_q;
      end
      ADDR_TVAL: begin
        rhit  = 1'b1;
        rdata = tval_q;
      end
      ADDR_TICLR: begin
        rhit  = 1'b1;
        rdata = 32'h0;
      end
      default: begin
        rhit  = 1'b0;
        rdata = 32'h0;
      end
    endcase
  end

  assign timer_int = timerInt_q;
  assign cnt_lo    = stableCnt_q[31:0];
  assign cnt_hi    = stableCnt_q[63:32];

endmodule

// File: tb/tb_csr_timer.sv
// Self-checking bench for csr_timer: a vector table for register access,
// then hand-written sequences for countdown, periodic reload, races and reset.
module tb_csr_timer;

  localparam logic [31:0] CORE_ID    = 32'hC0DE_0001;
  localparam logic [13:0] ADDR_TID   = 14'h40;
  localparam logic [13:0] ADDR_TCFG  = 14'h41;
  localparam logic [13:0] ADDR_TVAL  = 14'h42;
  localparam logic [13:0] ADDR_TICLR = 14'h44;

  logic        clk;
  logic        rst_n;
  logic        csrWen;
  logic [13:0] csrWaddr;
  logic [31:0] wdata;
  logic [13:0] csrRaddr;
  logic [31:0] rdata;
  logic        rhit;
  logic        timerInt;
  logic [31:0] cntLo;
  logic [31:0] cntHi;

  int testsRun;
  int testsFailed;

  typedef struct {
    logic        wen;
    logic [13:0] waddr;
    logic [31:0] wdata;
    logic [13:0] raddr;
    logic        expRhit;
    logic [31:0] expRdata;
    logic        expInt;
  } vec_t;

  vec_t vecs[12];

  csr_timer #(.CORE_ID(CORE_ID)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .csr_wen   (csrWen),
    .csr_waddr (csrWaddr),
    .wdata     (wdata),
    .csr_raddr (csrRaddr),
    .rdata     (rdata),
    .rhit      (rhit),
    .timer_int (timerInt),
    .cnt_lo    (cntLo),
    .cnt_hi    (cntHi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic wen, input logic [13:0] waddr,
                               input logic [31:0] data, input logic [13:0] raddr);
    csrWen   = wen;
    csrWaddr = waddr;
    wdata    = data;
    csrRaddr = raddr;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // One-cycle write; the read address is left on TVAL so the countdown stays visible.
  task automatic writeCsr(input logic [13:0] addr, input logic [31:0] data);
    applyStimulus(1'b1, addr, data, ADDR_TVAL);
    tick();
    applyStimulus(1'b0, 14'h0, 32'h0, ADDR_TVAL);
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;

    vecs[0]  = '{1'b0, 14'h00,     32'h0,         ADDR_TID,   1'b1, CORE_ID,       1'b0};
    vecs[1]  = '{1'b1, ADDR_TID,   32'hA5A5_0F0F, ADDR_TID,   1'b1, CORE_ID,       1'b0};
    vecs[2]  = '{1'b0, 14'h00,     32'h0,         ADDR_TID,   1'b1, 32'hA5A5_0F0F, 1'b0};
    vecs[3]  = '{1'b0, 14'h00,     32'h0,         14'h43,     1'b0, 32'h0,         1'b0};
    vecs[4]  = '{1'b0, 14'h00,     32'h0,         14'h00,     1'b0, 32'h0,         1'b0};
    vecs[5]  = '{1'b1, ADDR_TCFG,  32'h0000_0102, ADDR_TCFG,  1'b1, 32'h0,         1'b0};
    vecs[6]  = '{1'b0, 14'h00,     32'h0,         ADDR_TCFG,  1'b1, 32'h0000_0102, 1'b0};
    vecs[7]  = '{1'b0, 14'h00,     32'h0,         ADDR_TVAL,  1'b1, 32'h0000_0100, 1'b0};
    vecs[8]  = '{1'b1, ADDR_TVAL,  32'h5,         ADDR_TVAL,  1'b1, 32'h0000_0100, 1'b0};
    vecs[9]  = '{1'b0, 14'h00,     32'h0,         ADDR_TVAL,  1'b1, 32'h0000_0100, 1'b0};
    vecs[10] = '{1'b1, ADDR_TICLR, 32'hFFFF_FFFE, ADDR_TICLR, 1'b1, 32'h0,         1'b0};
    vecs[11] = '{1'b0, 14'h00,     32'h0,         ADDR_TICLR, 1'b1, 32'h0,         1'b0};

    // Power-on reset, released between clock edges.
    rst_n = 1'b0;
    applyStimulus(1'b0, 14'h0, 32'h0, ADDR_TID);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    checkOutput("reset_tid", rdata, CORE_ID);
    checkOutput("reset_int", {31'h0, timerInt}, 32'h0);
    checkOutput("reset_cnt_lo", cntLo, 32'h0);
    checkOutput("reset_cnt_hi", cntHi, 32'h0);
    csrRaddr = ADDR_TCFG;
    #1;
    checkOutput("reset_tcfg", rdata, 32'h0);
    repeat (3) tick();
    checkOutput("cnt_after_3", cntLo, 32'd3);
    checkOutput("cnt_hi_after_3", cntHi, 32'd0);

    $display("[TB] register access vectors");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].wen, vecs[i].waddr, vecs[i].wdata, vecs[i].raddr);
      #1;
      checkOutput($sformatf("vec%0d_rhit", i), {31'h0, rhit}, {31'h0, vecs[i].expRhit});
      checkOutput($sformatf("vec%0d_rdata", i), rdata, vecs[i].expRdata);
      checkOutput($sformatf("vec%0d_int", i), {31'h0, timerInt}, {31'h0, vecs[i].expInt});
      tick();
    end
    applyStimulus(1'b0, 14'h0, 32'h0, ADDR_TVAL);

    $display("[TB] one-shot countdown");
    writeCsr(ADDR_TCFG, 32'h0000_0011);
    for (int i = 0; i <= 16; i++) begin
      checkOutput($sformatf("oneshot_tval%0d", i), rdata, 32'h10 - 32'(i));
      checkOutput($sformatf("oneshot_int%0d", i), {31'h0, timerInt}, 32'h0);
      tick();
    end
    checkOutput("oneshot_expired_int", {31'h0, timerInt}, 32'h1);
    checkOutput("oneshot_expired_tval", rdata, 32'hFFFF_FFFF);
    repeat (3) tick();
    checkOutput("oneshot_hold_tval", rdata, 32'hFFFF_FFFF);
    checkOutput("oneshot_hold_int", {31'h0, timerInt}, 32'h1);
    writeCsr(ADDR_TICLR, 32'h1);
    checkOutput("oneshot_clear_int", {31'h0, timerInt}, 32'h0);

    $display("[TB] periodic reload and clear race");
    writeCsr(ADDR_TCFG, 32'h0000_000B);
    for (int c = 0; c <= 17; c++) begin
      checkOutput($sformatf("periodic_tval%0d", c), rdata, 32'd8 - 32'(c % 9));
      checkOutput($sformatf("periodic_int%0d", c), {31'h0, timerInt}, (c >= 9) ? 32'h1 : 32'h0);
      if (c == 17) applyStimulus(1'b1, ADDR_TICLR, 32'h1, ADDR_TVAL);
      tick();
    end
    applyStimulus(1'b0, 14'h0, 32'h0, ADDR_TVAL);
    checkOutput("race_set_wins", {31'h0, timerInt}, 32'h1);
    checkOutput("race_reload_tval", rdata, 32'h8);
    writeCsr(ADDR_TICLR, 32'h1);
    checkOutput("race_second_clear", {31'h0, timerInt}, 32'h0);
    checkOutput("race_tval_after", rdata, 32'h7);
    writeCsr(ADDR_TCFG, 32'h0);

    $display("[TB] reconfigure during countdown");
    writeCsr(ADDR_TCFG, 32'h0000_0011);
    repeat (15) tick();
    checkOutput("reconf_tval_one", rdata, 32'h1);
    writeCsr(ADDR_TCFG, 32'h0000_0011);
    checkOutput("reconf_reload", rdata, 32'h10);
    checkOutput("reconf_no_int", {31'h0, timerInt}, 32'h0);
    repeat (16) tick();
    checkOutput("reconf_tval_zero", rdata, 32'h0);
    writeCsr(ADDR_TCFG, 32'h0000_0011);
    checkOutput("tcfg_beats_expiry_tval", rdata, 32'h10);
    checkOutput("tcfg_beats_expiry_int", {31'h0, timerInt}, 32'h0);
    writeCsr(ADDR_TVAL, 32'h5);
    checkOutput("tval_write_ignored", rdata, 32'hF);

    $display("[TB] zero initial value");
    writeCsr(ADDR_TCFG, 32'h0000_0001);
    checkOutput("zero_init_tval", rdata, 32'h0);
    checkOutput("zero_init_int_before", {31'h0, timerInt}, 32'h0);
    tick();
    checkOutput("zero_init_int", {31'h0, timerInt}, 32'h1);
    checkOutput("zero_init_tval_after", rdata, 32'hFFFF_FFFF);
    writeCsr(ADDR_TICLR, 32'h1);
    checkOutput("zero_init_clear", {31'h0, timerInt}, 32'h0);

    $display("[TB] stable counter carry and wrap");
    force dut.stableCnt_q = 64'h0000_0007_FFFF_FFFF;
    #1;
    checkOutput("cnt_forced_lo", cntLo, 32'hFFFF_FFFF);
    checkOutput("cnt_forced_hi", cntHi, 32'h7);
    release dut.stableCnt_q;
    tick();
    checkOutput("cnt_carry_lo", cntLo, 32'h0);
    checkOutput("cnt_carry_hi", cntHi, 32'h8);
    force dut.stableCnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.stableCnt_q;
    tick();
    checkOutput("cnt_wrap_lo", cntLo, 32'h0);
    checkOutput("cnt_wrap_hi", cntHi, 32'h0);

    $display("[TB] reset mid-countdown");
    writeCsr(ADDR_TCFG, 32'h0000_0001);
    tick();
    writeCsr(ADDR_TCFG, 32'h0000_0011);
    repeat (3) tick();
    checkOutput("pre_reset_tval", rdata, 32'hD);
    checkOutput("pre_reset_int", {31'h0, timerInt}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_tval", rdata, 32'h0);
    checkOutput("async_reset_int", {31'h0, timerInt}, 32'h0);
    checkOutput("async_reset_cnt_lo", cntLo, 32'h0);
    checkOutput("async_reset_cnt_hi", cntHi, 32'h0);
    csrRaddr = ADDR_TID;
    #1;
    checkOutput("async_reset_tid", rdata, CORE_ID);
    #1;
    rst_n = 1'b1;
    csrRaddr = ADDR_TVAL;
    repeat (3) tick();
    checkOutput("post_reset_cnt", cntLo, 32'd3);
    checkOutput("post_reset_tval", rdata, 32'h0);
    checkOutput("post_reset_int", {31'h0, timerInt}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
